// File: rtl/cpu_regfile_pkg.sv
// Shared defaults, index-width helper and default-size types for the scoreboarded register file.
package cpu_regfile_pkg;

  localparam int REG_COUNT_DEF  = 32;
  localparam int DATA_WIDTH_DEF = 32;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW_DEF = addr_width(REG_COUNT_DEF);

  typedef logic [AW_DEF-1:0]         reg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/cpu_pend_counter.sv
// Saturating pending-write counter for one architectural register.
module cpu_pend_counter #(
  parameter int PEND_MAX = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_one,
  output logic is_max
);

  localparam int CW = $clog2(PEND_MAX + 1);

  logic [CW-1:0] count;

  // A simultaneous issue and writeback cancel out, including at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && !is_max) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !is_zero) begin
      count <= count - CW'(1);
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == CW'(1));
  assign is_max  = (count == CW'(PEND_MAX));

endmodule

// File: rtl/cpu_scoreboard_regfile.sv
// Register file with per-register pending-write counters for issue hazard checks.
// Optional same-cycle writeback forwarding is enabled by defining CPU_REGFILE_BYPASS_EN.
module cpu_scoreboard_regfile
  import cpu_regfile_pkg::*;
#(
  parameter int REG_COUNT  = REG_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int READ_PORTS = 2,
  parameter int PEND_MAX   = 3,
  localparam int AW        = addr_width(REG_COUNT)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             id_valid,
  output logic                             id_ready,
  input  logic [READ_PORTS*AW-1:0]         id_rs,
  input  logic [AW-1:0]                    id_rd,
  input  logic                             id_rd_we,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rs_data,
  output logic                             rs_valid,
  input  logic                             wb_en,
  input  logic [AW-1:0]                    wb_rd,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  output logic                             wb_err
);

`ifdef CPU_REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic [REG_COUNT-1:0] pend_zero;
  logic [REG_COUNT-1:0] pend_one;
  logic [REG_COUNT-1:0] pend_max;
  logic [REG_COUNT-1:0] pend_inc;
  logic [REG_COUNT-1:0] pend_dec;

  logic [READ_PORTS-1:0]            src_blocked;
  logic [READ_PORTS*DATA_WIDTH-1:0] operand;
  logic                             dst_blocked;
  logic                             issue_fire;

  // Register 0 is untracked: always idle, never full.
  assign pend_zero[0] = 1'b1;
  assign pend_one[0]  = 1'b0;
  assign pend_max[0]  = 1'b0;
  assign pend_inc[0]  = 1'b0;
  assign pend_dec[0]  = 1'b0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_pend
    assign pend_inc[i] = issue_fire && id_rd_we && (id_rd == AW'(i));
    assign pend_dec[i] = wb_en && (wb_rd == AW'(i));

    cpu_pend_counter #(.PEND_MAX(PEND_MAX)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (pend_inc[i]),
      .dec     (pend_dec[i]),
      .is_zero (pend_zero[i]),
      .is_one  (pend_one[i]),
      .is_max  (pend_max[i])
    );
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_src
    logic [AW-1:0] src_idx;
    logic          fwd;

    assign src_idx = id_rs[k*AW +: AW];
    // Only the last outstanding write may be forwarded; older ones would be overwritten.
    assign fwd = BYPASS_EN && wb_en && (wb_rd == src_idx) && pend_one[src_idx];
    assign src_blocked[k] = (src_idx != '0) && !pend_zero[src_idx] && !fwd;
    assign operand[k*DATA_WIDTH +: DATA_WIDTH] =
      (src_idx == '0) ? '0 : (fwd ? wb_data : regs[src_idx]);
  end

  assign dst_blocked = id_rd_we && (id_rd != '0) && pend_max[id_rd] &&
                       !(wb_en && (wb_rd == id_rd));
  assign id_ready    = !(|src_blocked) && !dst_blocked;
  assign issue_fire  = id_valid && id_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      rs_data  <= '0;
      rs_valid <= 1'b0;
      wb_err   <= 1'b0;
    end else begin
      if (wb_en && (wb_rd != '0)) begin
        regs[wb_rd] <= wb_data;
        if (pend_zero[wb_rd] && !pend_inc[wb_rd]) begin
          wb_err <= 1'b1;
        end
      end
      rs_valid <= issue_fire;
      if (issue_fire) begin
        rs_data <= operand;
      end
    end
  end

endmodule

// File: tb/tb_cpu_scoreboard_regfile.sv
// Self-checking bench: directed scenarios then random traffic against a counter-array reference model.
// Honours CPU_REGFILE_BYPASS_EN to select the forwarding expectations.
module tb_cpu_scoreboard_regfile;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int PM = 3;
`ifdef CPU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_valid = 1'b0;
  logic          id_ready;
  logic [2*AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rd = '0;
  logic          id_rd_we = 1'b0;
  logic [2*DW-1:0] rs_data;
  logic          rs_valid;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  int          m_pend [NR];
  logic [31:0] m_reg  [NR];
  logic        m_err;
  logic [63:0] m_rsdata;
  logic        m_rsvalid;
  bit          m_init = 0;

  always #5 clock = ~clock;

  cpu_scoreboard_regfile #(
    .REG_COUNT(NR), .DATA_WIDTH(DW), .READ_PORTS(2), .PEND_MAX(PM)
  ) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rd(id_rd), .id_rd_we(id_rd_we), .rs_data(rs_data),
    .rs_valid(rs_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit fwd_ok(int r, bit wbe, int wbr);
    return BYP && wbe && (wbr == r) && (m_pend[r] == 1);
  endfunction

  function automatic bit src_blk(int r, bit wbe, int wbr);
    return (r != 0) && (m_pend[r] != 0) && !fwd_ok(r, wbe, wbr);
  endfunction

  function automatic logic [31:0] src_val(int r, bit wbe, int wbr, logic [31:0] wbd);
    if (r == 0) return 32'h0;
    if (fwd_ok(r, wbe, wbr)) return wbd;
    return m_reg[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_pend[i] = 0;
      m_reg[i]  = 32'h0;
    end
    m_err     = 1'b0;
    m_rsdata  = '0;
    m_rsvalid = 1'b0;
  endtask

  task automatic step(input bit rst, input bit v, input int r0, input int r1,
                      input int rd, input bit we, input bit wbe, input int wbr,
                      input logic [31:0] wbd);
    bit exp_ready, acc;
    logic [31:0] op0, op1;
    int inc_r, dec_r;
    @(negedge clock);
    reset_n  = rst;
    id_valid = v;
    id_rs    = {5'(r1), 5'(r0)};
    id_rd    = 5'(rd);
    id_rd_we = we;
    wb_en    = wbe;
    wb_rd    = 5'(wbr);
    wb_data  = wbd;
    #1;
    exp_ready = !(src_blk(r0, wbe, wbr) || src_blk(r1, wbe, wbr) ||
                  (we && rd != 0 && m_pend[rd] == PM && !(wbe && wbr == rd)));
    if (m_init) chk("id_ready", 64'(id_ready), 64'(exp_ready));
    op0 = src_val(r0, wbe, wbr, wbd);
    op1 = src_val(r1, wbe, wbr, wbd);
    acc = v && exp_ready;
    @(posedge clock);
    if (!rst) begin
      model_reset();
      m_init = 1;
    end else begin
      inc_r = (acc && we && rd != 0) ? rd : -1;
      dec_r = (wbe && wbr != 0) ? wbr : -1;
      if (dec_r >= 0) m_reg[dec_r] = wbd;
      if (!(inc_r >= 0 && inc_r == dec_r)) begin
        if (inc_r >= 0) m_pend[inc_r]++;
        if (dec_r >= 0) begin
          if (m_pend[dec_r] > 0) m_pend[dec_r]--;
          else m_err = 1'b1;
        end
      end
      m_rsvalid = acc;
      if (acc) m_rsdata = {op1, op0};
    end
    #1;
    chk("rs_valid", 64'(rs_valid), 64'(m_rsvalid));
    chk("rs_data", rs_data, m_rsdata);
    chk("wb_err", 64'(wb_err), 64'(m_err));
  endtask

  initial begin
    int r0, r1, rd, wbr, start;
    bit v, we, wbe, rst;

    // 1: reset, then a plain read of untouched registers
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 5, 0, 0, 0, 0, 0);
    chk("t1_data", rs_data, 64'h0);

    // 2: RAW on r4 resolved by writeback
    step(1, 1, 0, 0, 4, 1, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 1, 4, 32'hDEADBEEF);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("t2_data", 64'(rs_data[31:0]), 64'hDEADBEEF);

    // 3: WAW chain on r7 up to saturation
    step(1, 1, 0, 0, 7, 1, 0, 0, 0);
    step(1, 1, 0, 0, 7, 1, 0, 0, 0);
    step(1, 1, 0, 0, 7, 1, 0, 0, 0);
    step(1, 1, 0, 0, 7, 1, 0, 0, 0);
    step(1, 1, 0, 0, 7, 1, 1, 7, 32'h77);
    chk("t3_accept", 64'(rs_valid), 64'h1);
    step(1, 1, 0, 0, 7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 7, 32'h70 + i);

    // 4: two writes pending on r9
    step(1, 1, 0, 0, 9, 1, 0, 0, 0);
    step(1, 1, 0, 0, 9, 1, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 1, 9, 32'h1);
    step(1, 1, 9, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 1, 9, 32'h2);
    step(1, 1, 0, 9, 0, 0, 0, 0, 0);
    chk("t4_data", 64'(rs_data[63:32]), 64'h2);

    // 5: stray writeback sets the sticky error; r0 is inert
    step(1, 0, 0, 0, 0, 0, 1, 12, 32'h55);
    step(1, 1, 12, 0, 0, 0, 0, 0, 0);
    chk("t5_data", 64'(rs_data[31:0]), 64'h55);
    step(1, 1, 0, 0, 0, 1, 1, 0, 32'hFFFF);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_r0", rs_data, 64'h0);

    // 6: reset discards in-flight state
    step(1, 1, 0, 0, 4, 1, 0, 0, 0);
    step(1, 1, 0, 0, 4, 1, 0, 0, 0);
    step(0, 1, 0, 0, 4, 1, 1, 4, 32'h1234);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("t6_data", rs_data, 64'h0);

    // random traffic over a small register window to force hazards
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      v   = ($urandom_range(0, 9) < 7);
      r0  = $urandom_range(0, 7);
      r1  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 7);
      we  = $urandom_range(0, 1);
      wbe = 0;
      wbr = 0;
      start = $urandom_range(1, 7);
      for (int j = 0; j < 7; j++) begin
        if (!wbe && m_pend[1 + (start + j) % 7] > 0 && $urandom_range(0, 2) != 0) begin
          wbe = 1;
          wbr = 1 + (start + j) % 7;
        end
      end
      if (!wbe && $urandom_range(0, 59) == 0) begin
        wbe = 1;
        wbr = $urandom_range(0, 7);
      end
      step(rst, v, r0, r1, rd, we, wbe, wbr, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
